// File: rtl/req_rr_arbiter_16.sv
// req_rr_arbiter_16: round-robin arbiter feeding the 16-to-4 enabled encoder.
// It turns 16 level-sensitive requests into a registered, strictly one-hot
// grant plus a valid strobe. A grant is held until the consumer acknowledges
// it or the timeout counter forces a release. Each release is followed by one
// idle cycle.
// Optional build macro ARB_FIXED_PRIO_EN: when it is defined, the round-robin
// pointer is pinned to 0. Selection then becomes fixed priority, with the
// lowest index highest. Ack and timeout behaviour do not change.
module req_rr_arbiter_16 #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        gnt_ack,
  output logic [15:0] gnt,
  output logic        gnt_vld,
  output logic        timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [15:0]      gnt_reg, gnt_next;
  logic             vld_reg, vld_next;
  logic             to_reg, to_next;
  logic [3:0]       ptr_reg, ptr_next;
  logic [3:0]       idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [15:0] rot_req;
  logic [3:0]  sel_off;
  logic [3:0]  sel_idx;
  logic        any_req;
  logic        timeout_hit;

  // Rotate the request vector so that bit 0 is the requester at ptr.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_rot
      logic [3:0] src_idx;
      assign src_idx     = ptr_reg + 4'(gi);
      assign rot_req[gi] = req[src_idx];
    end
  endgenerate

  // Find the lowest set bit of the rotated vector. This is the first
  // requester found when scanning upward from ptr.
  always_comb begin
    sel_off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rot_req[i]) sel_off = 4'(i);
    end
  end

  assign sel_idx = ptr_reg + sel_off;
  assign any_req = |req;

  // Timeout fires when the counter reaches TIMEOUT-1. A TIMEOUT of 0 disables it.
  generate
    if (TIMEOUT != 0) begin : g_to
      assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_to
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // Next-state logic: grant from IDLE, then hold the grant until ack or timeout.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    vld_next   = vld_reg;
    to_next    = 1'b0;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (en && any_req) begin
          gnt_next   = 16'(1) << sel_idx;
          vld_next   = 1'b1;
          idx_next   = sel_idx;
          cnt_next   = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (gnt_ack || timeout_hit) begin
          // Ack takes precedence: a tie with the timeout raises no pulse.
          gnt_next   = 16'd0;
          vld_next   = 1'b0;
          ptr_next   = idx_reg + 4'd1;
          to_next    = ~gnt_ack;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        gnt_next   = 16'd0;
        vld_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
`ifdef ARB_FIXED_PRIO_EN
    ptr_next = 4'd0;
`endif
  end

  // State registers. Reset drops any live grant at once and raises no timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= 16'd0;
      vld_reg   <= 1'b0;
      to_reg    <= 1'b0;
      ptr_reg   <= 4'd0;
      idx_reg   <= 4'd0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      vld_reg   <= vld_next;
      to_reg    <= to_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_vld = vld_reg;
  assign timeout = to_reg;

endmodule

// File: tb/tb_req_rr_arbiter_16.sv
// Bench for req_rr_arbiter_16 (TIMEOUT=4). It uses a directed vector table and
// hand-written sequences for rotation, timeout and mid-grant reset.
module tb_req_rr_arbiter_16;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] req = 16'd0;
  logic        gnt_ack = 1'b0;
  logic [15:0] gnt;
  logic        gnt_vld;
  logic        timeout;

  int pass_cnt = 0;
  int total_cnt = 0;

  req_rr_arbiter_16 #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .gnt_ack(gnt_ack),
    .gnt(gnt), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic        ack;
    logic [15:0] gnt;
    logic        vld;
    logic        to;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = 16'd0; gnt_ack = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Invariant: gnt is zero or one-hot, and gnt_vld tracks gnt != 0.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_onehot0", {15'd0, $onehot0(gnt)}, 16'd1);
      check("inv_vld", {15'd0, gnt_vld}, {15'd0, gnt != 16'd0});
    end
  end

  initial begin
    logic [15:0] exp;
    // Table: the inputs applied before an edge, then the outputs expected after it.
    vecs[0]  = '{1'b1, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b0}; // first grant
    vecs[1]  = '{1'b1, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0}; // ack, ptr=1
    vecs[2]  = '{1'b1, 16'h8001, 1'b0, FIXED ? 16'h0001 : 16'h8000, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 16'h8001, 1'b1, 16'h0000, 1'b0, 1'b0}; // ptr wraps to 0
    vecs[4]  = '{1'b1, 16'h8001, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 16'h8001, 1'b1, 16'h0000, 1'b0, 1'b0}; // ptr=1
    vecs[6]  = '{1'b0, 16'h0F00, 1'b0, 16'h0000, 1'b0, 1'b0}; // en=0 blocks
    vecs[7]  = '{1'b0, 16'h0F00, 1'b1, 16'h0000, 1'b0, 1'b0}; // ack in IDLE ignored
    vecs[8]  = '{1'b1, 16'h0F00, 1'b0, 16'h0100, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0100, 1'b1, 1'b0}; // en/req drop: held
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0}; // ptr=9
    vecs[11] = '{1'b1, 16'h0F00, 1'b0, FIXED ? 16'h0100 : 16'h0200, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 16'h0F00, 1'b1, 16'h0000, 1'b0, 1'b0};

    #1;
    check("reset_gnt", gnt, 16'd0);
    check("reset_vld", {15'd0, gnt_vld}, 16'd0);
    check("reset_to", {15'd0, timeout}, 16'd0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      en = vecs[i].en; req = vecs[i].req; gnt_ack = vecs[i].ack;
      step();
      $display("vec %0d: req=%h en=%0d ack=%0d -> gnt=%h vld=%0d to=%0d",
               i, req, en, gnt_ack, gnt, gnt_vld, timeout);
      check($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
      check($sformatf("vec%0d_vld", i), {15'd0, gnt_vld}, {15'd0, vecs[i].vld});
      check($sformatf("vec%0d_to", i), {15'd0, timeout}, {15'd0, vecs[i].to});
    end

    // With all requests set and ack held, grants rotate through every index and wrap.
    do_reset();
    en = 1'b1; req = 16'hFFFF; gnt_ack = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      exp = FIXED ? 16'h0001 : (16'h0001 << (k % 16));
      $display("rot %0d: gnt=%h", k, gnt);
      check($sformatf("rot%0d_gnt", k), gnt, exp);
      step();
      check($sformatf("rot%0d_idle", k), gnt, 16'd0);
    end

    // Timeout with a single requester: 4 valid cycles, release with a pulse, then re-grant.
    do_reset();
    en = 1'b1; req = 16'h0010; gnt_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("to_hold%0d", c), gnt, 16'h0010);
      check($sformatf("to_nopulse%0d", c), {15'd0, timeout}, 16'd0);
    end
    step();
    $display("timeout release: gnt=%h to=%0d", gnt, timeout);
    check("to_rel_gnt", gnt, 16'd0);
    check("to_rel_pulse", {15'd0, timeout}, 16'd1);
    step();
    check("to_regrant", gnt, 16'h0010);
    check("to_pulse_end", {15'd0, timeout}, 16'd0);
    // A second requester appears, so the next grant after the timeout goes to it.
    req = 16'h0030;
    for (int c = 0; c < 3; c++) step();
    check("to2_hold", gnt, 16'h0010);
    step();
    check("to2_pulse", {15'd0, timeout}, 16'd1);
    step();
    $display("after timeout: gnt=%h", gnt);
    check("to2_next", gnt, FIXED ? 16'h0010 : 16'h0020);
    // Ack on the same cycle the timeout would fire: release with no pulse.
    for (int c = 0; c < 3; c++) step();
    gnt_ack = 1'b1;
    step();
    check("tie_gnt", gnt, 16'd0);
    check("tie_nopulse", {15'd0, timeout}, 16'd0);
    gnt_ack = 1'b0;

    // Reset mid-grant: move ptr away from 0 first, reset, and check that ptr returns to 0.
    do_reset();
    en = 1'b1; req = 16'h0020; gnt_ack = 1'b0;
    step();
    gnt_ack = 1'b1; step();                 // ptr=6
    gnt_ack = 1'b0; req = 16'h0100; step(); // idle cycle
    step();
    check("mid_pre", gnt, 16'h0100);
    #2 rst = 1'b1;
    #1;
    $display("async reset: gnt=%h vld=%0d to=%0d", gnt, gnt_vld, timeout);
    check("mid_rst_gnt", gnt, 16'd0);
    check("mid_rst_vld", {15'd0, gnt_vld}, 16'd0);
    check("mid_rst_to", {15'd0, timeout}, 16'd0);
    step();
    rst = 1'b0; req = 16'hFFFF;
    step();
    check("mid_ptr0", gnt, 16'h0001);
    check("mid_after_to", {15'd0, timeout}, 16'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
